// File: rtl/dram_port_arbiter.sv
// Two-port round-robin arbiter and single-transaction sequencer in front of the
// tms4464 DRAM controller; aborts and flags a controller that stalls too long.
module dram_port_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [23:0] addr0,
    input  logic [23:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [7:0]  rdata0,
    output logic [7:0]  rdata1,
    output logic        mem_ena,
    output logic        mem_write,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic        mem_busy,
    input  logic [7:0]  mem_rdata,
    output logic        timeout
);

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              sel_q, sel_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ena_d, timeout_d;
    logic              gnt0_d, gnt1_d, done0_d, done1_d;
    logic [DATA_W-1:0] rdata0_d, rdata1_d;
    logic              pick;
    logic              fin;

    // Captured command stays on the controller bus from grant to the next grant.
    assign mem_write = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            cmd_q   <= '0;
            cnt_q   <= '0;
            mem_ena <= 1'b0;
            timeout <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            mem_ena <= ena_d;
            timeout <= timeout_d;
            gnt0    <= gnt0_d;
            gnt1    <= gnt1_d;
            done0   <= done0_d;
            done1   <= done1_d;
            rdata0  <= rdata0_d;
            rdata1  <= rdata1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        sel_d     = sel_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        ena_d     = mem_ena;
        timeout_d = timeout;
        rdata0_d  = rdata0;
        rdata1_d  = rdata1;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        pick      = 1'b0;
        fin       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Refresh in progress or a completion still showing blocks granting.
                if (!mem_busy && !done0 && !done1 && (req0 || req1)) begin
                    pick    = (req0 && req1) ? ~last_q : req1;
                    sel_d   = pick;
                    cmd_d   = pick ? mem_cmd_t'({we1, addr1, wdata1})
                                   : mem_cmd_t'({we0, addr0, wdata0});
                    ena_d   = 1'b1;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_ack) begin
                    ena_d   = 1'b0;
                    state_d = S_WAIT;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    ena_d     = 1'b0;
                    timeout_d = 1'b1;
                    fin       = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!mem_busy) begin
                    if (!cmd_q.we) begin
                        if (sel_q) rdata1_d = mem_rdata;
                        else       rdata0_d = mem_rdata;
                    end
                    last_d  = sel_q;
                    fin     = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    timeout_d = 1'b1;
                    fin       = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                ena_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        done0_d = fin & ~sel_q;
        done1_d = fin & sel_q;
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter with a behavioural tms4464 controller
// model and a completion scoreboard.
module tb_dram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [23:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1;
    logic [7:0]  rdata0, rdata1;
    logic        mem_ena, mem_write;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic        mem_busy;
    logic [7:0]  mem_rdata;
    logic        timeout;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic       port;
        logic       we;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    dram_port_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_ena(mem_ena), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_busy(mem_busy),
        .mem_rdata(mem_rdata), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model: acks after ack_dly enabled cycles, then busy for busy_len cycles.
    logic [7:0] mem [logic [23:0]];
    logic ack_en, refresh_busy, txn_busy;
    int   ack_dly, busy_len, wcnt, bcnt;
    logic m_busy_st;

    assign mem_busy = refresh_busy | txn_busy;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy_st = 1'b0;
            mem_ack   = 1'b0;
            txn_busy  = 1'b0;
            mem_rdata = 8'h00;
            wcnt      = 0;
            bcnt      = 0;
        end else if (!m_busy_st) begin
            mem_ack = 1'b0;
            if (mem_ena && ack_en) begin
                if (wcnt >= ack_dly) begin
                    mem_ack   = 1'b1;
                    txn_busy  = 1'b1;
                    bcnt      = busy_len;
                    wcnt      = 0;
                    m_busy_st = 1'b1;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end else begin
            mem_ack = 1'b0;
            if (bcnt > 0) begin
                bcnt--;
            end else begin
                txn_busy = 1'b0;
                if (mem_write) mem[mem_addr] = mem_wdata;
                else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
                m_busy_st = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic p, input logic we, input logic [7:0] d);
        exp_t e;
        e.port = p;
        e.we   = we;
        e.data = d;
        sb.push_back(e);
    endtask

    // Completion monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt0 || gnt1)
                chk("gnt_overlap", 32'({gnt0 & gnt1, gnt0 & (done0 | done1), gnt1 & (done0 | done1)}), 32'd0);
            if (done0 || done1) begin
                exp_t e;
                done_cnt++;
                chk("done_excl", 32'(done0 & done1), 32'd0);
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("done_port", 32'(done1), 32'(e.port));
                    if (!e.we) chk("rdata", 32'(e.port ? rdata1 : rdata0), 32'(e.data));
                end
            end
        end
    end

    task automatic wait_gnt(input logic p, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(p ? gnt1 : gnt0) && lat < 60);
        chk("gnt_seen", 32'(p ? gnt1 : gnt0), 32'd1);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic do_txn(input logic p, input logic we, input logic [23:0] a,
                          input logic [7:0] wd, input logic [7:0] exp_rd);
        int lat, start;
        @(negedge clk);
        if (p) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
        else   begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
        push_exp(p, we, exp_rd);
        start = done_cnt;
        wait_gnt(p, lat);
        chk("gnt_latency", 32'(lat), 32'd1);
        chk("gnt_addr", 32'(mem_addr), 32'(a));
        chk("gnt_write", 32'(mem_write), 32'(we));
        if (we) chk("gnt_wdata", 32'(mem_wdata), 32'(wd));
        if (p) req1 = 1'b0; else req0 = 1'b0;
        wait_done(start + 1);
        chk("addr_hold", 32'(mem_addr), 32'(a));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, start, hold, n;
        logic p;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        refresh_busy = 1'b0; ack_en = 1'b1; ack_dly = 0; busy_len = 1;
        mem[24'h000200] = 8'h5C;
        mem[24'h000000] = 8'h01;
        repeat (3) @(negedge clk);
        chk("rst_ena", 32'(mem_ena), 32'd0);
        chk("rst_bus", 32'({mem_write, mem_addr, mem_wdata}), 32'd0);
        chk("rst_pulses", 32'({gnt0, gnt1, done0, done1}), 32'd0);
        chk("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Contention right after reset: port 0 must win first, then strict alternation.
        push_exp(1'b0, 1'b0, 8'h01); push_exp(1'b1, 1'b0, 8'h5C);
        push_exp(1'b0, 1'b0, 8'h01); push_exp(1'b1, 1'b0, 8'h5C);
        start = done_cnt;
        req0 = 1'b1; we0 = 1'b0; addr0 = 24'h000000;
        req1 = 1'b1; we1 = 1'b0; addr1 = 24'h000200;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(gnt0 || gnt1) && n < 60);
            chk("cont_gnt_seen", 32'(gnt0 | gnt1), 32'd1);
            p = gnt1;
            chk("cont_order", 32'(p), 32'(k % 2));
            if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
        end
        wait_done(start + 4);

        // Single write then read of the same address.
        do_txn(1'b0, 1'b1, 24'h000100, 8'h02, 8'h00);
        do_txn(1'b0, 1'b0, 24'h000100, 8'h00, 8'h02);
        chk("wr_rd_rdata0", 32'(rdata0), 32'h02);
        chk("wr_rd_timeout", 32'(timeout), 32'd0);

        // Refresh hold-off for 20 cycles.
        @(negedge clk);
        refresh_busy = 1'b1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 24'h000200;
        push_exp(1'b1, 1'b0, 8'h5C);
        start = done_cnt;
        hold = 0;
        repeat (20) begin
            @(negedge clk);
            if (gnt1 || mem_ena) hold++;
        end
        chk("refresh_hold", 32'(hold), 32'd0);
        refresh_busy = 1'b0;
        wait_gnt(1'b1, lat);
        chk("refresh_gnt_lat", 32'(lat), 32'd1);
        req1 = 1'b0;
        wait_done(start + 1);

        // Data isolation between ports.
        do_txn(1'b1, 1'b1, 24'hFFFFFF, 8'hA5, 8'h00);
        chk("iso_rdata1_wr", 32'(rdata1), 32'h5C);
        do_txn(1'b0, 1'b0, 24'h000000, 8'h00, 8'h01);
        chk("iso_rdata1", 32'(rdata1), 32'h5C);
        chk("iso_rdata0", 32'(rdata0), 32'h01);

        // Ack timeout: controller never acknowledges.
        ack_en = 1'b0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 24'h000300;
        push_exp(1'b0, 1'b0, 8'h01);
        start = done_cnt;
        wait_gnt(1'b0, lat);
        req0 = 1'b0;
        n = 0;
        while (mem_ena && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("to_ena_cycles", 32'(n), 32'd15);
        wait_done(start + 1);
        chk("to_flag", 32'(timeout), 32'd1);
        ack_en = 1'b1;
        do_txn(1'b1, 1'b0, 24'h000200, 8'h00, 8'h5C);
        chk("to_sticky", 32'(timeout), 32'd1);

        // Reset while the controller is busy in WAIT.
        busy_len = 8;
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 24'h000100;
        wait_gnt(1'b1, lat);
        req1 = 1'b0;
        n = 0;
        while (mem_ena && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rw_in_wait", 32'(mem_ena), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_ena", 32'(mem_ena), 32'd0);
        chk("rw_bus", 32'({mem_write, mem_addr, mem_wdata}), 32'd0);
        chk("rw_rdata", 32'({rdata0, rdata1}), 32'd0);
        chk("rw_timeout", 32'(timeout), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rw_no_done", 32'({done0, done1}), 32'd0);
        end
        rst_n = 1'b1;
        busy_len = 1;
        do_txn(1'b0, 1'b0, 24'h000100, 8'h00, 8'h02);
        chk("rw_after_timeout", 32'(timeout), 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
